// File: rtl/axil_reg_pkg.sv
// Shared constants and FSM encodings for the AXI-lite register slave.
package axil_reg_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
endpackage

// File: rtl/axil_reg_slave.sv
// AXI-lite register bank: independent write/read FSMs, byte strobes,
// read-only registers fed from reg_in, programmable read latency.
module axil_reg_slave
  import axil_reg_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int NUM_REGS     = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter int READ_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          s_axil_awaddr,
  input  logic [2:0]                     s_axil_awprot,
  input  logic                           s_axil_awvalid,
  output logic                           s_axil_awready,
  input  logic [DATA_WIDTH-1:0]          s_axil_wdata,
  input  logic [STRB_WIDTH-1:0]          s_axil_wstrb,
  input  logic                           s_axil_wvalid,
  output logic                           s_axil_wready,
  output logic [1:0]                     s_axil_bresp,
  output logic                           s_axil_bvalid,
  input  logic                           s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axil_araddr,
  input  logic [2:0]                     s_axil_arprot,
  input  logic                           s_axil_arvalid,
  output logic                           s_axil_arready,
  output logic [DATA_WIDTH-1:0]          s_axil_rdata,
  output logic [1:0]                     s_axil_rresp,
  output logic                           s_axil_rvalid,
  input  logic                           s_axil_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);
  localparam int LSB   = $clog2(STRB_WIDTH);
  localparam int IDX_W = ADDR_WIDTH - LSB;
  localparam int CNT_W = 3;
  localparam logic [IDX_W:0] NREG = (IDX_W+1)'(NUM_REGS);

  if (NUM_REGS < 1 || NUM_REGS > 256 || READ_LATENCY < 1 || READ_LATENCY > 8 ||
      (DATA_WIDTH % 8) != 0) begin : g_param_chk
    $error("axil_reg_slave: illegal parameter set");
  end

  logic w_unused;
  assign w_unused = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[LSB-1:0], s_axil_araddr[LSB-1:0]};

  // ---------------- write path ----------------
  wr_state_t r_wstate, w_wnext;
  logic                                 r_aw_done, r_w_done;
  logic [IDX_W-1:0]                     r_widx;
  logic [DATA_WIDTH-1:0]                r_wdata;
  logic [STRB_WIDTH-1:0]                r_wstrb;
  logic [1:0]                           r_bresp;
  logic [NUM_REGS-1:0]                  r_wr_pulse;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  r_regs;
  logic w_aw_hs, w_w_hs, w_commit;

  assign w_aw_hs  = s_axil_awvalid & s_axil_awready;
  assign w_w_hs   = s_axil_wvalid & s_axil_wready;
  // The write lands on the edge that moves IDLE -> COMMIT, so wr_pulse is
  // visible during COMMIT and bvalid follows one cycle later.
  assign w_commit = (r_wstate == W_IDLE) & r_aw_done & r_w_done;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_wstate <= W_IDLE;
    else        r_wstate <= w_wnext;

  always_comb begin
    w_wnext = r_wstate;
    case (r_wstate)
      W_IDLE:   if (r_aw_done && r_w_done) w_wnext = W_COMMIT;
      W_COMMIT: w_wnext = W_RESP;
      W_RESP:   if (s_axil_bready) w_wnext = W_IDLE;
      default:  w_wnext = W_IDLE;
    endcase
  end

  always_comb begin
    s_axil_awready = 1'b0;
    s_axil_wready  = 1'b0;
    s_axil_bvalid  = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        s_axil_awready = !r_aw_done;
        s_axil_wready  = !r_w_done;
      end
      W_RESP:  s_axil_bvalid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_widx    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      if (w_aw_hs) begin
        r_aw_done <= 1'b1;
        r_widx    <= s_axil_awaddr[ADDR_WIDTH-1:LSB];
      end
      if (w_w_hs) begin
        r_w_done <= 1'b1;
        r_wdata  <= s_axil_wdata;
        r_wstrb  <= s_axil_wstrb;
      end
      if (w_commit) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_regs     <= '0;
      r_wr_pulse <= '0;
      r_bresp    <= RESP_OKAY;
    end else begin
      r_wr_pulse <= '0;
      if (w_commit) begin
        r_bresp <= ({1'b0, r_widx} < NREG) ? RESP_OKAY : RESP_SLVERR;
        for (int i = 0; i < NUM_REGS; i++)
          if (r_widx == IDX_W'(i) && !RO_MASK[i]) begin
            r_wr_pulse[i] <= |r_wstrb;
            for (int b = 0; b < STRB_WIDTH; b++)
              if (r_wstrb[b]) r_regs[i][b*8 +: 8] <= r_wdata[b*8 +: 8];
          end
      end
    end

  assign s_axil_bresp = r_bresp;
  assign reg_out      = r_regs;
  assign wr_pulse     = r_wr_pulse;

  // ---------------- read path ----------------
  rd_state_t r_rstate, w_rnext;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_ridx, w_ridx;
  logic [DATA_WIDTH-1:0] r_rdata, w_rd_val;
  logic [1:0]            r_rresp;
  logic w_ar_hs, w_capture;

  assign w_ar_hs   = s_axil_arvalid & s_axil_arready;
  // With latency 1 the capture edge is the AR edge itself, so use the live address.
  assign w_ridx    = (r_rstate == R_IDLE) ? s_axil_araddr[ADDR_WIDTH-1:LSB] : r_ridx;
  assign w_capture = (w_rnext == R_RESP) && (r_rstate != R_RESP);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rstate <= R_IDLE;
    else        r_rstate <= w_rnext;

  always_comb begin
    w_rnext = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rnext = (READ_LATENCY == 1) ? R_RESP : R_WAIT;
      R_WAIT:  if (r_cnt == '0) w_rnext = R_RESP;
      R_RESP:  if (s_axil_rready) w_rnext = R_IDLE;
      default: w_rnext = R_IDLE;
    endcase
  end

  always_comb begin
    s_axil_arready = (r_rstate == R_IDLE);
    s_axil_rvalid  = (r_rstate == R_RESP);
  end

  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (w_ridx == IDX_W'(i))
        w_rd_val = RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt   <= '0;
      r_ridx  <= '0;
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else begin
      if (w_ar_hs) begin
        r_ridx <= s_axil_araddr[ADDR_WIDTH-1:LSB];
        r_cnt  <= CNT_W'(READ_LATENCY - 1);
      end else if (r_rstate == R_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_capture) begin
        r_rdata <= w_rd_val;
        r_rresp <= ({1'b0, w_ridx} < NREG) ? RESP_OKAY : RESP_SLVERR;
      end
    end

  assign s_axil_rdata = r_rdata;
  assign s_axil_rresp = r_rresp;
endmodule
